io_bus_bridge: RTL and testbench

- Parametrised, handshaked successor to the MCS I/O slot decoder.
- Sits between the MCS bus master and NUM_SLOTS peripheral slots.
- Decodes slot and register addresses and registers each transaction through a small FSM.
- Waits on a per-slot ready, returns registered read data with a bus_ready pulse, and flags decode or timeout errors on bus_err.

---
 rtl/io_bus_bridge_if.sv | 35 +++
 rtl/io_bus_bridge.sv | 149 ++++++++++++++
 tb/tb_io_bus_bridge.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_bridge_if.sv
// Bus-side and slot-side signal bundle of io_bus_bridge.
// The bridge connects through the slave modport; the environment uses the master modport.
interface io_bus_bridge_if #(
    parameter int NUM_SLOTS = 16,
    parameter int REG_AW    = 5,
    parameter int DATA_W    = 32
);
    logic                          bus_cs;
    logic                          bus_rd;
    logic                          bus_wr;
    logic [31:0]                   bus_addr;
    logic [DATA_W-1:0]             bus_wr_data;
    logic [DATA_W-1:0]             bus_rd_data;
    logic                          bus_ready;
    logic                          bus_err;
    logic [NUM_SLOTS-1:0]          slot_cs;
    logic                          slot_rd;
    logic                          slot_wr;
    logic [REG_AW-1:0]             slot_reg_addr;
    logic [DATA_W-1:0]             slot_wr_data;
    logic [NUM_SLOTS*DATA_W-1:0]   slot_rd_data;
    logic [NUM_SLOTS-1:0]          slot_ready;

    modport slave (
        input  bus_cs, bus_rd, bus_wr, bus_addr, bus_wr_data, slot_rd_data, slot_ready,
        output bus_rd_data, bus_ready, bus_err, slot_cs, slot_rd, slot_wr,
               slot_reg_addr, slot_wr_data
    );

    modport master (
        output bus_cs, bus_rd, bus_wr, bus_addr, bus_wr_data, slot_rd_data, slot_ready,
        input  bus_rd_data, bus_ready, bus_err, slot_cs, slot_rd, slot_wr,
               slot_reg_addr, slot_wr_data
    );
endinterface

// File: rtl/io_bus_bridge.sv
// Handshaked MCS bus to NUM_SLOTS peripheral-slot bridge (IDLE -> ACCESS -> RESP).
// Optional ACCESS timeout enabled by defining IO_BRIDGE_TIMEOUT_EN.
module io_bus_bridge #(
    parameter int NUM_SLOTS   = 16,
    parameter int REG_AW      = 5,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    io_bus_bridge_if.slave  bus
);
    localparam int SLOT_AW = $clog2(NUM_SLOTS);
    localparam int SLOT_LO = REG_AW + 2;
    localparam int SLOT_HI = REG_AW + SLOT_AW + 1;
    localparam logic [SLOT_AW:0] SLOT_LIMIT = (SLOT_AW + 1)'(NUM_SLOTS);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e              state_q, state_d;
    logic [SLOT_AW-1:0]  slot_q, slot_d;
    logic [REG_AW-1:0]   reg_q, reg_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                is_rd_q, is_rd_d;
    logic                err_q, err_d;

    logic [SLOT_AW-1:0]  req_slot;
    logic                req_any;
    logic                req_bad;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_data;
    logic                in_access;

    assign req_slot  = bus.bus_addr[SLOT_HI:SLOT_LO];
    assign req_any   = bus.bus_cs && (bus.bus_rd || bus.bus_wr);
    assign req_bad   = (bus.bus_rd && bus.bus_wr) || ({1'b0, req_slot} >= SLOT_LIMIT);
    assign sel_ready = bus.slot_ready[slot_q];
    assign sel_data  = bus.slot_rd_data[int'(slot_q)*DATA_W +: DATA_W];
    assign in_access = (state_q == ACCESS);

    // Address bits outside the slot/register fields carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.bus_addr[31:SLOT_HI+1], bus.bus_addr[1:0]};

`ifdef IO_BRIDGE_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             timed_out;

    assign cnt_inc   = cnt_q + 1'b1;
    assign timed_out = (cnt_inc == CNT_W'(TIMEOUT_CYC));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        reg_d     = reg_q;
        wr_data_d = wr_data_q;
        rd_data_d = rd_data_q;
        is_rd_d   = is_rd_q;
        err_d     = err_q;
`ifdef IO_BRIDGE_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    slot_d    = req_slot;
                    reg_d     = bus.bus_addr[REG_AW+1:2];
                    wr_data_d = bus.bus_wr_data;
                    is_rd_d   = bus.bus_rd && !bus.bus_wr;
                    if (req_bad) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        if (bus.bus_rd && !bus.bus_wr) rd_data_d = '0;
                    end else begin
                        state_d = ACCESS;
                        err_d   = 1'b0;
`ifdef IO_BRIDGE_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ACCESS: begin
                // Ready wins over a timeout landing in the same cycle.
                if (sel_ready) begin
                    if (is_rd_q) rd_data_d = sel_data;
                    err_d   = 1'b0;
                    state_d = RESP;
`ifdef IO_BRIDGE_TIMEOUT_EN
                end else if (timed_out) begin
                    if (is_rd_q) rd_data_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_inc;
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            reg_q     <= '0;
            wr_data_q <= '0;
            rd_data_q <= '0;
            is_rd_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef IO_BRIDGE_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            reg_q     <= reg_d;
            wr_data_q <= wr_data_d;
            rd_data_q <= rd_data_d;
            is_rd_q   <= is_rd_d;
            err_q     <= err_d;
`ifdef IO_BRIDGE_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.bus_rd_data   = rd_data_q;
    assign bus.bus_ready     = (state_q == RESP);
    assign bus.bus_err       = (state_q == RESP) && err_q;
    assign bus.slot_cs       = in_access ? ({{(NUM_SLOTS-1){1'b0}}, 1'b1} << slot_q) : '0;
    assign bus.slot_rd       = in_access && is_rd_q;
    assign bus.slot_wr       = in_access && !is_rd_q;
    assign bus.slot_reg_addr = reg_q;
    assign bus.slot_wr_data  = wr_data_q;
endmodule

// File: tb/tb_io_bus_bridge.sv
// Directed, table-driven bench for io_bus_bridge (12 slots, TIMEOUT_CYC=4).
// Timeout expectations follow IO_BRIDGE_TIMEOUT_EN when it is defined for the build.
module tb_io_bus_bridge;
    localparam int NS = 12;
    localparam int RW = 5;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    io_bus_bridge_if #(.NUM_SLOTS(NS), .REG_AW(RW), .DATA_W(DW)) bus_if ();

    io_bus_bridge #(
        .NUM_SLOTS(NS), .REG_AW(RW), .DATA_W(DW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    typedef struct {
        logic          cs, rd, wr;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [31:0]   rdata_in;
        int            slot;
        int            wait_cyc;
        bit            noise;
        bit            derr;
        logic [NS-1:0] exp_cs;
        logic [RW-1:0] exp_reg;
        logic [31:0]   exp_rdata;
    } vec_t;

    vec_t vecs[9];
    vec_t post_rst;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus_if.bus_cs = 1'b0;
        bus_if.bus_rd = 1'b0;
        bus_if.bus_wr = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".slot_cs"},   64'(bus_if.slot_cs),   64'h0);
        check({tag, ".slot_rd"},   64'(bus_if.slot_rd),   64'h0);
        check({tag, ".slot_wr"},   64'(bus_if.slot_wr),   64'h0);
        check({tag, ".bus_ready"}, 64'(bus_if.bus_ready), 64'h0);
    endtask

    // Called at a falling edge with the bridge idle; returns at a falling edge, idle again.
    task automatic do_txn(input vec_t v, input string tag);
        bus_if.bus_cs      = v.cs;
        bus_if.bus_rd      = v.rd;
        bus_if.bus_wr      = v.wr;
        bus_if.bus_addr    = v.addr;
        bus_if.bus_wr_data = v.wdata;
        if (!v.derr) bus_if.slot_rd_data[v.slot*DW +: DW] = v.rdata_in;
        if (v.derr) begin
            @(negedge clk);
            idle_inputs();
            check({tag, ".err_ready"},   64'(bus_if.bus_ready),   64'h1);
            check({tag, ".err_flag"},    64'(bus_if.bus_err),     64'h1);
            check({tag, ".err_cs"},      64'(bus_if.slot_cs),     64'h0);
            check({tag, ".err_strobe"},  64'(bus_if.slot_rd | bus_if.slot_wr), 64'h0);
            check({tag, ".err_rdata"},   64'(bus_if.bus_rd_data), 64'(v.exp_rdata));
        end else begin
            for (int c = 0; c <= v.wait_cyc; c++) begin
                @(negedge clk);
                if (c == 0) idle_inputs();
                check({tag, ".cs"},        64'(bus_if.slot_cs),       64'(v.exp_cs));
                check({tag, ".rd"},        64'(bus_if.slot_rd),       64'(v.rd));
                check({tag, ".wr"},        64'(bus_if.slot_wr),       64'(v.wr));
                check({tag, ".reg"},       64'(bus_if.slot_reg_addr), 64'(v.exp_reg));
                check({tag, ".wdata"},     64'(bus_if.slot_wr_data),  64'(v.wdata));
                check({tag, ".early_rdy"}, 64'(bus_if.bus_ready),     64'h0);
                bus_if.slot_ready = v.noise ? ~(NS'(1) << v.slot) : '0;
                if (c == v.wait_cyc) bus_if.slot_ready[v.slot] = 1'b1;
            end
            @(negedge clk);
            bus_if.slot_ready = '0;
            check({tag, ".ready"},     64'(bus_if.bus_ready),   64'h1);
            check({tag, ".err"},       64'(bus_if.bus_err),     64'h0);
            check({tag, ".rdata"},     64'(bus_if.bus_rd_data), 64'(v.exp_rdata));
            check({tag, ".resp_cs"},   64'(bus_if.slot_cs),     64'h0);
        end
        @(negedge clk);
        check({tag, ".ready_drop"}, 64'(bus_if.bus_ready),   64'h0);
        check({tag, ".rdata_hold"}, 64'(bus_if.bus_rd_data), 64'(v.exp_rdata));
    endtask

    initial begin
        //          cs rd wr addr           wdata          rdata_in       slot wait noise derr exp_cs    reg    exp_rdata
        vecs[0] = '{1, 0, 1, 32'h0000_0388, 32'hA5A5_1234, 32'h0,          7,  0,   0,    0,   12'h080,  5'd2,  32'h0};
        vecs[1] = '{1, 1, 0, 32'h0000_0084, 32'h1111_2222, 32'hDEAD_BEEF,  1,  2,   0,    0,   12'h002,  5'd1,  32'hDEAD_BEEF};
        vecs[2] = '{1, 0, 1, 32'hFFFF_FDFF, 32'h1357_9BDF, 32'h0,          11, 1,   1,    0,   12'h800,  5'd31, 32'hDEAD_BEEF};
        vecs[3] = '{1, 1, 0, 32'h0000_0000, 32'h0,         32'h0123_4567,  0,  0,   1,    0,   12'h001,  5'd0,  32'h0123_4567};
        vecs[4] = '{1, 1, 0, 32'h0000_018C, 32'h0,         32'h89AB_CDEF,  3,  3,   0,    0,   12'h008,  5'd3,  32'h89AB_CDEF};
        vecs[5] = '{1, 0, 1, 32'h0000_0600, 32'h5555_AAAA, 32'h0,          12, 0,   0,    1,   12'h000,  5'd0,  32'h89AB_CDEF};
        vecs[6] = '{1, 1, 0, 32'h0000_0680, 32'h0,         32'h0,          13, 0,   0,    1,   12'h000,  5'd0,  32'h0};
        vecs[7] = '{1, 1, 1, 32'h0000_0388, 32'h0,         32'h0,          7,  0,   0,    1,   12'h000,  5'd0,  32'h0};
        vecs[8] = '{1, 1, 0, 32'h0000_028C, 32'h0,         32'hCAFE_F00D,  5,  0,   0,    0,   12'h020,  5'd3,  32'hCAFE_F00D};
        post_rst = '{1, 0, 1, 32'h0000_0110, 32'h600D_F00D, 32'h0,         2,  1,   0,    0,   12'h004,  5'd4,  32'h0};

        reset_n            = 1'b0;
        idle_inputs();
        bus_if.bus_addr    = '0;
        bus_if.bus_wr_data = '0;
        bus_if.slot_ready  = '0;
        for (int i = 0; i < NS; i++) bus_if.slot_rd_data[i*DW +: DW] = 32'hC0DE_0000 | 32'(i);

        repeat (2) @(negedge clk);
        check_quiet("reset");
        check("reset.rdata",  64'(bus_if.bus_rd_data),   64'h0);
        check("reset.err",    64'(bus_if.bus_err),       64'h0);
        check("reset.reg",    64'(bus_if.slot_reg_addr), 64'h0);
        check("reset.wdata",  64'(bus_if.slot_wr_data),  64'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Incomplete requests must leave the bridge idle.
        bus_if.bus_rd = 1'b1;
        bus_if.bus_addr = 32'h0000_0388;
        @(negedge clk);
        check_quiet("nocs");
        bus_if.bus_cs = 1'b1;
        bus_if.bus_rd = 1'b0;
        @(negedge clk);
        check_quiet("noop");
        idle_inputs();
        @(negedge clk);
        check_quiet("noop_after");

        for (int i = 0; i < 9; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Slot 3 read with no ready from the slot.
        bus_if.slot_rd_data[3*DW +: DW] = 32'h0BAD_CAFE;
        bus_if.bus_cs   = 1'b1;
        bus_if.bus_rd   = 1'b1;
        bus_if.bus_addr = 32'h0000_0180;
`ifdef IO_BRIDGE_TIMEOUT_EN
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            if (c == 0) idle_inputs();
            check("tmo.rd",        64'(bus_if.slot_rd),   64'h1);
            check("tmo.no_ready",  64'(bus_if.bus_ready), 64'h0);
        end
        @(negedge clk);
        check("tmo.ready", 64'(bus_if.bus_ready),   64'h1);
        check("tmo.err",   64'(bus_if.bus_err),     64'h1);
        check("tmo.rdata", 64'(bus_if.bus_rd_data), 64'h0);
        @(negedge clk);
        check("tmo.drop",  64'(bus_if.bus_ready),   64'h0);
`else
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) idle_inputs();
            check("wait.rd",       64'(bus_if.slot_rd),   64'h1);
            check("wait.no_ready", 64'(bus_if.bus_ready), 64'h0);
            if (c == 19) bus_if.slot_ready[3] = 1'b1;
        end
        @(negedge clk);
        bus_if.slot_ready = '0;
        check("wait.ready", 64'(bus_if.bus_ready),   64'h1);
        check("wait.err",   64'(bus_if.bus_err),     64'h0);
        check("wait.rdata", 64'(bus_if.bus_rd_data), 64'h0BAD_CAFE);
        @(negedge clk);
`endif

        // Reset while a write to slot 2 is in ACCESS.
        bus_if.bus_cs      = 1'b1;
        bus_if.bus_wr      = 1'b1;
        bus_if.bus_addr    = 32'h0000_0110;
        bus_if.bus_wr_data = 32'h600D_F00D;
        @(negedge clk);
        idle_inputs();
        check("rstmid.wr", 64'(bus_if.slot_wr), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        check_quiet("rstmid");
        check("rstmid.err",   64'(bus_if.bus_err),       64'h0);
        check("rstmid.rdata", 64'(bus_if.bus_rd_data),   64'h0);
        check("rstmid.reg",   64'(bus_if.slot_reg_addr), 64'h0);
        check("rstmid.wdata", 64'(bus_if.slot_wr_data),  64'h0);
        repeat (2) begin
            @(negedge clk);
            check("rstmid.hold_ready", 64'(bus_if.bus_ready), 64'h0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check_quiet("rstmid_rel");
        do_txn(post_rst, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
